// File: rtl/cpu_pkg.sv
// cpu_pkg: shared widths, reset PC and fetch entry type for the 19-bit CPU
package cpu_pkg;
  localparam int ADDR_W = 19;
  localparam int INSTR_W = 19;
  localparam logic [ADDR_W-1:0] DEFAULT_RESET_PC = '0;
  typedef struct packed {
    logic [ADDR_W-1:0]  pc;
    logic [INSTR_W-1:0] instr;
  } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// fetch_fifo: DEPTH-entry prefetch queue of fetch entries; flush beats push
module fetch_fifo import cpu_pkg::*; #(
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     flush,
  input  logic                     push,
  input  logic                     pop,
  input  fetch_entry_t             din,
  output fetch_entry_t             dout,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  fetch_entry_t mem [DEPTH];
  logic [AW-1:0] rd, wr;
  // entry storage; contents are only visible through count, so no reset
  always_ff @(posedge clk)
    if (push && !flush) mem[wr] <= din;
  // pointers and occupancy; pointers wrap naturally as DEPTH is a power of two
  always_ff @(posedge clk) begin
    if (flush) begin
      rd    <= '0;
      wr    <= '0;
      count <= '0;
    end else begin
      if (push) wr <= wr + 1'b1;
      if (pop) rd <= rd + 1'b1;
      count <= count + {{AW{1'b0}}, push} - {{AW{1'b0}}, pop};
    end
  end
  assign dout = mem[rd];
endmodule

// File: rtl/fetch_unit.sv
// fetch_unit: owns the fetch PC, issues credit-limited imem reads and queues results for decode
module fetch_unit import cpu_pkg::*; #(
  parameter int                DEPTH    = 4,
  parameter logic [ADDR_W-1:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic               clk,
  input  logic               reset,
  output logic               imem_req,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_pc,
  output logic               out_valid,
  output logic [INSTR_W-1:0] out_instr,
  output logic [ADDR_W-1:0]  out_pc,
  input  logic               out_ready
);
  localparam int CW = $clog2(DEPTH) + 1;
  logic [ADDR_W-1:0] fpc, inf_pc;
  logic              inf;
  logic [CW-1:0]     occ;
  fetch_entry_t      head;
  // a read is only issued when the queue is guaranteed room for its data
  assign imem_req  = !reset && !redirect_valid && (occ + CW'(inf) < CW'(DEPTH));
  assign imem_addr = reset ? RESET_PC : fpc;
  assign out_valid = occ != '0;
  assign out_instr = out_valid ? head.instr : '0;
  assign out_pc    = out_valid ? head.pc : '0;
  // fetch PC and in-flight tracking; redirect kills the outstanding read
  always_ff @(posedge clk) begin
    if (reset) begin
      fpc    <= RESET_PC;
      inf    <= 1'b0;
      inf_pc <= '0;
    end else if (redirect_valid) begin
      fpc <= redirect_pc;
      inf <= 1'b0;
    end else begin
      inf <= imem_req;
      if (imem_req) begin
        fpc    <= fpc + 1'b1;
        inf_pc <= fpc;
      end
    end
  end
  fetch_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk   (clk),
    .flush (reset || redirect_valid),
    .push  (inf && !redirect_valid && !reset),
    .pop   (out_valid && out_ready),
    .din   ('{pc: inf_pc, instr: imem_rdata}),
    .dout  (head),
    .count (occ)
  );
endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage of the 19-bit CPU, directly upstream of decode/control and the register file. Owns the fetch PC and issues word-addressed reads to a synchronous instruction memory with a fixed 1-cycle read latency. Buffers returned instructions in a small prefetch queue and hands them to decode over a valid/ready handshake. Accepts a redirect (branch/jump target) that flushes the queue and kills the in-flight read.

## Interface
- ADDR_W, 19, PC / instruction-memory address width (word addresses)
- INSTR_W, 19, instruction width
- DEPTH, 4, prefetch queue entries; power of two, ≥4
- RESET_PC, 19'd0, first fetch address after reset
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high
- imem_req  out  1  read request this cycle
- imem_addr  out  ADDR_W  read address; meaningful when imem_req=1
- imem_rdata  in  INSTR_W  read data, valid exactly one cycle after imem_req=1
- redirect_valid  in  1  load new fetch PC, flush queue
- redirect_pc  in  ADDR_W  redirect target
- out_valid  out  1  queue head holds a valid instruction
- out_instr  out  INSTR_W  head instruction (0 when out_valid=0)
- out_pc  out  ADDR_W  address of out_instr (0 when out_valid=0)
- out_ready  in  1  decode accepts head this cycle

## Operation
- State: fetch PC fpc, in-flight flag inf with captured address inf_pc, queue occupancy occ (width clog2(DEPTH)+1).
- Issue rule: imem_req = !reset && !redirect_valid && (occ + inf < DEPTH); imem_addr = fpc. On issue: fpc <= fpc+1 (ADDR_W-bit, wraps 19'h7FFFF → 0), inf <= 1, inf_pc <= fpc; otherwise inf <= 0.
- Response: if inf=1 and no redirect this cycle, push {inf_pc, imem_rdata} into queue.
- Pop: out_valid && out_ready removes head. Push and pop in the same cycle: occ unchanged.
- Credit rule guarantees push never hits a full queue; no lookahead on pop.
- Redirect (priority over everything): fpc <= redirect_pc; queue cleared (occ <= 0); inf <= 0 so the returning data is discarded; no request that cycle; redirect_pc is requested the next cycle. A handshake (out_valid && out_ready) in the redirect cycle counts as completed. Back-to-back redirects: last one wins; a request goes out only in the first cycle without redirect.
- No bypass: out_valid derives only from occ≠0.

## Timing
- During reset, and in the cycle after: imem_req=0, imem_addr=RESET_PC, out_valid=0, out_instr=0, out_pc=0; fpc=RESET_PC, occ=0, inf=0.
- Reset mid-operation: same as above on the next edge; in-flight data discarded.
- First cycle with reset low (T0): imem_req=1, imem_addr=RESET_PC. Data sampled at end of T1, out_valid=1 in T2 with out_pc=RESET_PC.
- Fetch-to-decode latency: 2 cycles from request. Redirect-to-first-valid: 3 cycles (redirect cycle T, request T+1, valid T+3).
- Throughput: 1 instruction/cycle with out_ready held high (steady state occ=1, inf=1).
- With out_ready low: requests stop once occ+inf=DEPTH; queue holds DEPTH instructions, no loss, no duplicates.
- Outputs out_* driven combinationally from the queue head register; no combinational path from out_ready or imem_rdata to imem_req.

## Structure
- cpu_pkg (shared): ADDR_W=19, INSTR_W=19, RESET_PC constant, fetch entry typedef {pc, instr}.
- Sub-module fetch_fifo: synchronous DEPTH-entry FIFO of fetch entries with push, pop, flush, count; flush has priority over push.
- fetch_unit holds fpc, in-flight tracking, credit logic, redirect handling.

## Test plan
- Reset release, memory returns instr = addr XOR 19'h5A5A5, out_ready=1: requests at 0,1,2,…; out_valid first in T2; out_pc sequence 0,1,2,… each cycle with matching instr.
- out_ready=0 from reset for 10 cycles: exactly 4 requests (0..3), then imem_req=0; raise out_ready: instructions 0..3 delivered in order, fetching resumes at 4.
- Redirect to 19'h01234 while occ=3 and inf=1: no request that cycle; next cycle imem_addr=19'h01234; discarded data never appears; next out_pc=19'h01234.
- Redirect simultaneous with accepted pop: popped instruction counted once; queue empty after; two consecutive redirect cycles to A then B: first request is B.
- RESET_PC=19'h7FFFE: out_pc sequence 7FFFE, 7FFFF, 00000, 00001.
- Assert reset for one cycle with queue full and read in flight: all outputs return to reset values; fetch restarts at RESET_PC.
